// File: rtl/wb_queue_if.sv
// Request/issue bundle for the writeback queue: two producer handshakes, flush,
// and the registered select/data/valid plus occupancy seen by the decoder side.
interface wb_queue_if #(
    parameter int unsigned AW = 2
);
    logic        mem_vld;
    logic        mem_rdy;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        alu_vld;
    logic        alu_rdy;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        flush;
    logic [5:0]  loadsel;
    logic [31:0] wdata;
    logic        wvld;
    logic [AW:0] count;

    modport master (
        output mem_vld, mem_rd, mem_data, alu_vld, alu_rd, alu_data, flush,
        input  mem_rdy, alu_rdy, loadsel, wdata, wvld, count
    );

    modport slave (
        input  mem_vld, mem_rd, mem_data, alu_vld, alu_rd, alu_data, flush,
        output mem_rdy, alu_rdy, loadsel, wdata, wvld, count
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback request queue: merges memory and ALU register writes into one FIFO
// and issues one write per cycle. Optional macro WBQ_BYPASS_EN skips the FIFO when empty.
module wb_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 2,
    parameter logic [5:0]  IDLE_SEL = 6'd32
) (
    input  logic        clk,
    input  logic        rstn,
    wb_queue_if.slave   bus
);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t         fifo [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [CW-1:0]     count_q, count_next, free;
    logic [5:0]        sel_q, sel_next;
    logic [31:0]       data_q, data_next;
    logic              vld_q, vld_next;

    logic              mem_rdy_c, alu_rdy_c, mem_acc, alu_acc, pop;
    logic              wen0, wen1;
    wb_entry_t         wdat0, wdat1, mem_ent, alu_ent, head;

    assign mem_ent = '{rd: bus.mem_rd, data: bus.mem_data};
    assign alu_ent = '{rd: bus.alu_rd, data: bus.alu_data};
    assign head    = fifo[rptr];

    // Space check uses the registered count; a same-cycle pop is not credited.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        mem_rdy_c = rstn & ~bus.flush & (free >= CW'(1));
        alu_rdy_c = rstn & ~bus.flush & (bus.mem_vld ? (free >= CW'(2)) : (free >= CW'(1)));
        mem_acc   = bus.mem_vld & mem_rdy_c;
        alu_acc   = bus.alu_vld & alu_rdy_c;
        pop       = (count_q != '0);
    end

    assign bus.mem_rdy = mem_rdy_c;
    assign bus.alu_rdy = alu_rdy_c;

    // Push slot selection and next output register contents.
    always_comb begin
        wen0      = mem_acc | alu_acc;
        wdat0     = mem_acc ? mem_ent : alu_ent;
        wen1      = mem_acc & alu_acc;
        wdat1     = alu_ent;
        sel_next  = IDLE_SEL;
        data_next = '0;
        vld_next  = 1'b0;
        if (pop) begin
            sel_next  = {1'b0, head.rd};
            data_next = head.data;
            vld_next  = 1'b1;
        end
`ifdef WBQ_BYPASS_EN
        else if (mem_acc | alu_acc) begin
            // Empty queue: the higher-priority request goes straight to the output.
            sel_next  = {1'b0, wdat0.rd};
            data_next = wdat0.data;
            vld_next  = 1'b1;
            wen0      = mem_acc & alu_acc;
            wdat0     = alu_ent;
            wen1      = 1'b0;
        end
`endif
        count_next = count_q + CW'(wen0) + CW'(wen1) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn || bus.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            sel_q   <= IDLE_SEL;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            wptr    <= wptr + AW'(wen0) + AW'(wen1);
            rptr    <= rptr + AW'(pop);
            count_q <= count_next;
            sel_q   <= sel_next;
            data_q  <= data_next;
            vld_q   <= vld_next;
        end
    end

    // Storage needs no reset; readies are low in reset/flush so nothing is written.
    always_ff @(posedge clk) begin
        if (wen0) fifo[wptr] <= wdat0;
        if (wen1) fifo[wptr + AW'(1)] <= wdat1;
    end

    assign bus.loadsel = sel_q;
    assign bus.wdata   = data_q;
    assign bus.wvld    = vld_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with flush/reset.
module tb_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_queue_if #(.AW(AW)) bus ();

    wb_queue #(.DEPTH(DEPTH), .AW(AW), .IDLE_SEL(6'd32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    ent_t        q[$];
    logic [5:0]  e_sel  = 6'd32;
    logic [31:0] e_data = '0;
    logic        e_vld  = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        obs_mrdy, obs_ardy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive, check readies, advance model, check registered outputs.
    task automatic step(input logic rs, input logic fl,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
        int   free;
        logic em, ea;
        ent_t acc[$];
        ent_t e;
        @(negedge clk);
        rstn = rs; bus.flush = fl;
        bus.mem_vld = mv; bus.mem_rd = mr; bus.mem_data = md;
        bus.alu_vld = av; bus.alu_rd = ar; bus.alu_data = ad;
        #1;
        free = DEPTH - q.size();
        em = rs && !fl && (free >= 1);
        ea = rs && !fl && (mv ? (free >= 2) : (free >= 1));
        obs_mrdy = bus.mem_rdy;
        obs_ardy = bus.alu_rdy;
        chk("mem_rdy", 32'(obs_mrdy), 32'(em));
        chk("alu_rdy", 32'(obs_ardy), 32'(ea));
        @(posedge clk);
        if (!rs || fl) begin
            q.delete();
            e_sel = 6'd32; e_data = '0; e_vld = 1'b0;
        end else begin
            if (mv && em) acc.push_back('{rd: mr, data: md});
            if (av && ea) acc.push_back('{rd: ar, data: ad});
            if (q.size() > 0) begin
                e = q.pop_front();
                e_sel = {1'b0, e.rd}; e_data = e.data; e_vld = 1'b1;
            end
`ifdef WBQ_BYPASS_EN
            else if (acc.size() > 0) begin
                e = acc.pop_front();
                e_sel = {1'b0, e.rd}; e_data = e.data; e_vld = 1'b1;
            end
`endif
            else begin
                e_sel = 6'd32; e_data = '0; e_vld = 1'b0;
            end
            foreach (acc[i]) q.push_back(acc[i]);
        end
        #1;
        chk("loadsel", 32'(bus.loadsel), 32'(e_sel));
        chk("wdata",   bus.wdata,        e_data);
        chk("wvld",    32'(bus.wvld),    32'(e_vld));
        chk("count",   32'(bus.count),   32'(q.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic fill_to3();
        for (int i = 0; i < 8 && q.size() != 3; i++)
            step(1'b1, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(i + 8), 32'h200 + 32'(i));
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.mem_vld = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.alu_vld = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;

        // Reset held with mem_vld asserted
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 5'd1, 32'h55, 1'b0, 5'd0, 32'd0);
            chk("rst_mem_rdy", 32'(bus.mem_rdy), 32'd0);
        end
        chk("rst_loadsel", 32'(bus.loadsel), 32'd32);
        chk("rst_wdata",   bus.wdata,        32'd0);
        chk("rst_wvld",    32'(bus.wvld),    32'd0);
        chk("rst_count",   32'(bus.count),   32'd0);
        idle(1);
        chk("post_rst_mem_rdy", 32'(bus.mem_rdy), 32'd1);

        // Single ALU write
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef WBQ_BYPASS_EN
        chk("alu1_sel",  32'(bus.loadsel), 32'd5);
        chk("alu1_data", bus.wdata,        32'hDEADBEEF);
`else
        chk("alu1_idle", 32'(bus.wvld), 32'd0);
        idle(1);
        chk("alu1_sel",  32'(bus.loadsel), 32'd5);
        chk("alu1_data", bus.wdata,        32'hDEADBEEF);
`endif
        idle(1);
        chk("alu1_after", 32'(bus.loadsel), 32'd32);

        // Simultaneous same-rd requests: memory first
        step(1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
`ifndef WBQ_BYPASS_EN
        idle(1);
`endif
        chk("sim_first",  bus.wdata, 32'h11);
        idle(1);
        chk("sim_second", bus.wdata, 32'h22);
        chk("sim_sel",    32'(bus.loadsel), 32'd3);
        idle(2);

        // Priority at free=1
        fill_to3();
        chk("prio_count", 32'(bus.count), 32'd3);
        step(1'b1, 1'b0, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd21, 32'hA1);
        chk("prio_mem_rdy", 32'(obs_mrdy), 32'd1);
        chk("prio_alu_rdy", 32'(obs_ardy), 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hA1);
        chk("prio_alu_next", 32'(obs_ardy), 32'd1);

        // Flush with both ports valid
        fill_to3();
        step(1'b1, 1'b1, 1'b1, 5'd30, 32'hF0, 1'b1, 5'd31, 32'hF1);
        chk("flush_rdy",   32'(obs_mrdy | obs_ardy), 32'd0);
        chk("flush_count", 32'(bus.count),   32'd0);
        chk("flush_sel",   32'(bus.loadsel), 32'd32);
        idle(1);
        chk("flush_noissue", 32'(bus.wvld), 32'd0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(15) == 0),
                 1'($urandom_range(1)), 5'($urandom), $urandom,
                 1'($urandom_range(1)), 5'($urandom), $urandom);
        end
        idle(DEPTH + 2);
        chk("drained_count", 32'(bus.count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
